// File: rtl/mem_pkg.sv
// Shared definitions for the data memory arbiter and the memory it fronts.
//   state_t      controller state (IDLE / ACCESS / DONE, 2-bit encoding)
//   *_DEFAULT    memory placement defaults (byte base of word 0, word count)
//   addr_fault() address range / alignment check used at grant time
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int OFFSET_DEFAULT = 1024;
    localparam int DEPTH_DEFAULT  = 64;
    localparam int WAIT_WIDTH     = 4;

    // Operands are zero-extended to 64 bits by the caller. The word index is
    // only meaningful when addr >= offset; the OR short-circuits the wrapped
    // case, so the subtraction behaves as a non-wrapping one.
    function automatic logic addr_fault(input logic [63:0] addr,
                                        input logic [63:0] offset,
                                        input logic [63:0] depth);
        logic [63:0] word;
        word = (addr - offset) >> 2;
        return (addr[1:0] != 2'b00) || (addr < offset) || (word >= depth);
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals of data_mem_arbiter.
//   Req/We/Addr/WData (x2)  requester -> arbiter
//   Ready/Err/RData   (x2)  arbiter -> requester
//   Address/WriteData/MemRead/MemWrite  arbiter -> memory
//   ReadData                memory -> arbiter
// Handshake: a requester raises ReqN with WeN/AddrN/WDataN stable and keeps
// them until ReadyN; ReadyN is a single-cycle pulse, ErrN/RDataN are valid in
// that cycle, and the requester drops ReqN in the following cycle. A ReqN
// seen high while the arbiter is idle is always treated as a new request.
interface data_mem_arbiter_if #(
    parameter int WORD_SIZE    = 32,
    parameter int ADDRESS_SIZE = 32
);
    logic                    Req0;
    logic                    Req1;
    logic                    We0;
    logic                    We1;
    logic [ADDRESS_SIZE-1:0] Addr0;
    logic [ADDRESS_SIZE-1:0] Addr1;
    logic [WORD_SIZE-1:0]    WData0;
    logic [WORD_SIZE-1:0]    WData1;
    logic                    Ready0;
    logic                    Ready1;
    logic                    Err0;
    logic                    Err1;
    logic [WORD_SIZE-1:0]    RData0;
    logic [WORD_SIZE-1:0]    RData1;
    logic [ADDRESS_SIZE-1:0] Address;
    logic [WORD_SIZE-1:0]    WriteData;
    logic                    MemRead;
    logic                    MemWrite;
    logic [WORD_SIZE-1:0]    ReadData;

    modport slave (
        input  Req0, Req1, We0, We1, Addr0, Addr1, WData0, WData1, ReadData,
        output Ready0, Ready1, Err0, Err1, RData0, RData1,
               Address, WriteData, MemRead, MemWrite
    );

    modport master (
        output Req0, Req1, We0, We1, Addr0, Addr1, WData0, WData1, ReadData,
        input  Ready0, Ready1, Err0, Err1, RData0, RData1,
               Address, WriteData, MemRead, MemWrite
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, rst   clock, asynchronous active-high reset
//   en         arbitration allowed this cycle (controller idle)
//   req0/req1  requests
//   grant      one-hot grant, bit 0 = port 0; zero when en is low
// The pointer remembers the port granted last; on a tie the other port wins.
// It resets to 1 so port 0 takes the first tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       req0,
    input  logic       req1,
    output logic [1:0] grant
);
    logic last_q;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req0 && req1) begin
                grant = last_q ? 2'b01 : 2'b10;
            end else if (req0) begin
                grant = 2'b01;
            end else if (req1) begin
                grant = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (grant[0]) begin
            last_q <= 1'b0;
        end else if (grant[1]) begin
            last_q <= 1'b1;
        end
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// Shares a single-port data memory between the MEM stage (port 0) and an
// auxiliary master (port 1).
//   clk, rst   clock, asynchronous active-high reset
//   bus        requester handshakes and memory pins (data_mem_arbiter_if)
//   state_dbg  current controller state
// One access per grant: IDLE (arbitrate, latch operands, fault check) ->
// ACCESS (WAIT_CYCLES+1 cycles, strobes driven) -> DONE (Ready pulse).
// Faulting addresses skip ACCESS, so the memory never sees them.
module data_mem_arbiter
    import mem_pkg::*;
#(
    parameter int WORD_SIZE    = 32,
    parameter int ADDRESS_SIZE = 32,
    parameter int OFFSET       = OFFSET_DEFAULT,
    parameter int DEPTH        = DEPTH_DEFAULT,
    parameter int WAIT_CYCLES  = 0
) (
    input  logic                clk,
    input  logic                rst,
    data_mem_arbiter_if.slave   bus,
    output state_t              state_dbg
);
    state_t                  state;
    state_t                  state_n;
    logic [1:0]              gnt;
    logic [WAIT_WIDTH-1:0]   cnt;
    logic                    id_q;
    logic                    we_q;
    logic                    fault_q;
    logic [ADDRESS_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0]    wdata_q;
    logic [WORD_SIZE-1:0]    rdata0_q;
    logic [WORD_SIZE-1:0]    rdata1_q;

    logic                    sel_we;
    logic [ADDRESS_SIZE-1:0] sel_addr;
    logic [WORD_SIZE-1:0]    sel_wdata;
    logic                    sel_fault;
    logic                    in_access;
    logic                    in_done;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (state == IDLE),
        .req0  (bus.Req0),
        .req1  (bus.Req1),
        .grant (gnt)
    );

    // Operand mux for the port being granted this cycle.
    assign sel_we    = gnt[1] ? bus.We1    : bus.We0;
    assign sel_addr  = gnt[1] ? bus.Addr1  : bus.Addr0;
    assign sel_wdata = gnt[1] ? bus.WData1 : bus.WData0;
    assign sel_fault = addr_fault(64'(sel_addr), 64'(OFFSET), 64'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (gnt != 2'b00) state_n = sel_fault ? DONE : ACCESS;
            ACCESS:  if (cnt == '0) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand latches, wait counter and per-port read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            id_q     <= 1'b0;
            we_q     <= 1'b0;
            fault_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt != 2'b00) begin
                        id_q    <= gnt[1];
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        fault_q <= sel_fault;
                        cnt     <= WAIT_WIDTH'(WAIT_CYCLES);
                        // A faulted completion reports zero read data.
                        if (sel_fault) begin
                            if (gnt[1]) rdata1_q <= '0;
                            else        rdata0_q <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!we_q) begin
                        if (id_q) rdata1_q <= bus.ReadData;
                        else      rdata0_q <= bus.ReadData;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_access = (state == ACCESS);
    assign in_done   = (state == DONE);

    // Strobes and memory bus are decoded from state so an asynchronous reset
    // clears them immediately. The write strobe is confined to the final
    // ACCESS cycle so the memory sees exactly one write edge.
    assign bus.Address   = in_access ? addr_q  : '0;
    assign bus.WriteData = in_access ? wdata_q : '0;
    assign bus.MemRead   = in_access && !we_q;
    assign bus.MemWrite  = in_access && we_q && (cnt == '0);

    assign bus.Ready0 = in_done && !id_q;
    assign bus.Ready1 = in_done &&  id_q;
    assign bus.Err0   = in_done && !id_q && fault_q;
    assign bus.Err1   = in_done &&  id_q && fault_q;
    assign bus.RData0 = rdata0_q;
    assign bus.RData1 = rdata1_q;

    assign state_dbg = state;
endmodule
